lut_cfg_loader: RTL and testbench
=================================

Name: lut_cfg_loader

Overview:
Upstream configuration stage for the LUT chain. It accepts configuration words over a valid/ready interface and serializes them into CONFIG_WIDTH-bit slices. It drives the LUT chain's config input and config enable so that NUM_LUTS daisy-chained LUTs are fully loaded, then reports completion. It sits between the bitstream source (bench or fabric config controller) and lut_cfg_chain[0] / cfg_en of the LUT array.

Parameters:
LUT_NINPUTS, 4, address inputs per LUT; the LUT memory holds 2**LUT_NINPUTS bits
CONFIG_WIDTH, 1, bits shifted into the chain per enabled clock
NUM_LUTS, 4, number of LUTs in the chain
WORD_WIDTH, 32, input word width; must be a multiple of CONFIG_WIDTH (elaboration error otherwise)

Ports:
clk  in  1  system / config clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE
word_in  in  WORD_WIDTH  configuration word; least-significant slice is shifted first
word_valid  in  1  word_in is valid
word_ready  out  1  loader accepts word_in this cycle
config_en  out  1  chain shift enable, broadcast to every LUT's config_en
config_data  out  CONFIG_WIDTH  slice presented to lut_cfg_chain[0]
busy  out  1  high in LOAD and SHIFT
done  out  1  high from load completion until the next start or reset

Behaviour:
- Derived values: TOTAL_SLICES = NUM_LUTS*2**LUT_NINPUTS/CONFIG_WIDTH; SLICES_PER_WORD = WORD_WIDTH/CONFIG_WIDTH; NUM_WORDS = ceil(TOTAL_SLICES/SLICES_PER_WORD). Unused high slices of the final word are discarded.
- Reset (async): state=IDLE; shift register, slice counter and total counter are 0. All outputs are 0.
- States are IDLE, LOAD, SHIFT and DONE. Every output is a function of registered state only; there is no combinational path from inputs to outputs.
- IDLE or DONE: on start, go to LOAD, clear the counters and drop done. Start is ignored in LOAD and SHIFT.
- LOAD: word_ready=1 and config_en=0. On word_valid, latch word_in into the shift register, set slice_idx=0 and go to SHIFT.
- SHIFT:
  - config_en=1 and config_data=shreg[CONFIG_WIDTH-1:0].
  - Each cycle: shreg shifts right by CONFIG_WIDTH, slice_idx increments and total_cnt increments.
  - If total_cnt==TOTAL_SLICES-1, go to DONE.
  - Otherwise, if slice_idx==SLICES_PER_WORD-1: word_ready=1 this cycle. If word_valid, reload shreg with no bubble and stay in SHIFT. If not, go to LOAD (a stall).
- Stall: config_en=0, so the chain holds its contents. The total count of config_en-high cycles is always exactly TOTAL_SLICES.
- DONE: done=1, config_en=0, word_ready=0.
- Latency: start at cycle T gives LOAD at T+1. A word valid at T+1 gives SHIFT at T+2. With no stalls, config_en is high for cycles T+2 .. T+1+TOTAL_SLICES, and done rises at T+2+TOTAL_SLICES.
- Reset during LOAD or SHIFT aborts the load: return to IDLE with all outputs 0. The chain contents are undefined until a full reload.
- word_valid outside word_ready has no effect; the source holds the word until accepted.

Decomposition:
- Package lut_cfg_pkg holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3);
  - functions or localparams for LUT_MEM_SIZE, LOADING_CYCLES (=LUT_MEM_SIZE/CONFIG_WIDTH), TOTAL_SLICES, SLICES_PER_WORD, NUM_WORDS;
  - a clog2 helper for counter widths.
- One sub-module, lut_cfg_serializer: word shift register plus slice_idx, with load/shift/last_slice signals. The FSM and total_cnt stay in lut_cfg_loader.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> word_ready, config_en, config_data, busy and done all 0 immediately; state IDLE.
- NUM_LUTS=1, CONFIG_WIDTH=1: start, then word 0x0000A5C3 -> config_en high for exactly 16 cycles with config_data 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. Upper 16 bits are never shifted. done is high on the following cycle. A LUT model then reads addr 0 -> 1 and addr 15 -> 1.
- Defaults: words 0xDEADBEEF and 0x01234567, both valid back-to-back -> word_ready high in cycle 32 of SHIFT, config_en high for 64 contiguous cycles, the bitstream equals the concatenated LSB-first words, done is high at start+66.
- Stall: second word withheld 5 cycles -> config_en low for those cycles and config_data unchanged. Total config_en-high cycles still 64; the final chain contents match the no-stall case.
- Reset after 10 slices -> IDLE, all outputs 0. A subsequent start with a full two-word load completes normally with 64 enables.
- Start pulses in SHIFT are ignored (enable count unchanged). Start in DONE drops done next cycle and begins a new load. CONFIG_WIDTH=2 build: 32 enables of 2-bit slices for the default 4 LUTs.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared state encoding and size helpers for the LUT configuration loader.
// All derived sizes are functions of the loader parameters.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Counter width, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

  function automatic int lut_mem_size(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int loading_cycles(input int n_in, input int cw);
    return lut_mem_size(n_in) / cw;
  endfunction

  function automatic int total_slices(input int n_in, input int cw, input int n_luts);
    return n_luts * loading_cycles(n_in, cw);
  endfunction

  function automatic int slices_per_word(input int ww, input int cw);
    return ww / cw;
  endfunction

  function automatic int num_words(input int n_in, input int cw, input int n_luts, input int ww);
    return (total_slices(n_in, cw, n_luts) + slices_per_word(ww, cw) - 1) / slices_per_word(ww, cw);
  endfunction

endpackage

// File: rtl/lut_cfg_serializer.sv
// Word shift register and slice index: presents the word LSB slice first.
// Load wins over shift so a back-to-back reload never inserts a bubble.
module lut_cfg_serializer
  import lut_cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = 1,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    shift,
  input  logic [WORD_WIDTH-1:0]   word,
  output logic [CONFIG_WIDTH-1:0] slice,
  output logic                    last_slice
);

  localparam int SPW   = slices_per_word(WORD_WIDTH, CONFIG_WIDTH);
  localparam int IDX_W = cnt_w(SPW);

  logic [WORD_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      slice_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      slice_idx <= '0;
    end else if (load) begin
      shreg     <= word;
      slice_idx <= '0;
    end else if (shift) begin
      shreg     <= shreg >> CONFIG_WIDTH;
      slice_idx <= slice_idx + 1'b1;
    end else if (clr) begin
      slice_idx <= '0;
    end
  end

  assign slice      = shreg[CONFIG_WIDTH-1:0];
  assign last_slice = (slice_idx == IDX_W'(SPW - 1));

endmodule

// File: rtl/lut_cfg_loader.sv
// Streams configuration words into the LUT daisy chain, one slice per enabled
// clock, and flags completion after exactly TOTAL_SLICES enables.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int LUT_NINPUTS  = 4,
  parameter int CONFIG_WIDTH = 1,
  parameter int NUM_LUTS     = 4,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    config_en,
  output logic [CONFIG_WIDTH-1:0] config_data,
  output logic                    busy,
  output logic                    done
);

  localparam int TOTAL = total_slices(LUT_NINPUTS, CONFIG_WIDTH, NUM_LUTS);
  localparam int TOT_W = cnt_w(TOTAL);

  if (WORD_WIDTH % CONFIG_WIDTH != 0) begin : g_bad_width
    $error("WORD_WIDTH must be a multiple of CONFIG_WIDTH");
  end

  cfg_state_t       state;
  logic [TOT_W-1:0] total_cnt;
  logic             last_slice;
  logic             last_total;
  logic             load;
  logic             shift;
  logic             clr;

  assign last_total = (total_cnt == TOT_W'(TOTAL - 1));
  // Ready depends on registered state only; the final word's spare slices are dropped.
  assign word_ready = (state == LOAD) || ((state == SHIFT) && last_slice && !last_total);
  assign load       = word_ready && word_valid;
  assign shift      = (state == SHIFT);
  assign clr        = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      total_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            total_cnt <= '0;
          end
        end
        LOAD: begin
          if (word_valid) state <= SHIFT;
        end
        SHIFT: begin
          total_cnt <= total_cnt + 1'b1;
          if (last_total) state <= DONE;
          else if (last_slice && !word_valid) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  lut_cfg_serializer #(
    .CONFIG_WIDTH(CONFIG_WIDTH),
    .WORD_WIDTH  (WORD_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (load),
    .shift     (shift),
    .word      (word_in),
    .slice     (config_data),
    .last_slice(last_slice)
  );

  assign config_en = (state == SHIFT);
  assign busy      = (state == LOAD) || (state == SHIFT);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader: default build, a one-LUT build and a
// two-bit-slice build, each with a chain model fed from config_en/config_data.
module tb_lut_cfg_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default build: 4 LUTs, 1-bit slices
  logic        start_d, valid_d, ready_d, en_d, data_d, busy_d, done_d;
  logic [31:0] word_d;
  // one-LUT build
  logic        start_o, valid_o, ready_o, en_o, data_o, busy_o, done_o;
  logic [31:0] word_o;
  // 2-bit slice build
  logic        start_w, valid_w, ready_w, en_w, busy_w, done_w;
  logic [1:0]  data_w;
  logic [31:0] word_w;

  lut_cfg_loader u_dut (
    .clk(clk), .rst(rst), .start(start_d), .word_in(word_d), .word_valid(valid_d),
    .word_ready(ready_d), .config_en(en_d), .config_data(data_d), .busy(busy_d), .done(done_d));

  lut_cfg_loader #(.NUM_LUTS(1)) u_one (
    .clk(clk), .rst(rst), .start(start_o), .word_in(word_o), .word_valid(valid_o),
    .word_ready(ready_o), .config_en(en_o), .config_data(data_o), .busy(busy_o), .done(done_o));

  lut_cfg_loader #(.CONFIG_WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(start_w), .word_in(word_w), .word_valid(valid_w),
    .word_ready(ready_w), .config_en(en_w), .config_data(data_w), .busy(busy_w), .done(done_w));

  // Chain models: each enabled cycle pushes the slice in at the top.
  int          n_en_d = 0, n_en_o = 0, n_en_w = 0;
  logic [63:0] chain_d = '0, chain_w = '0;
  logic [15:0] mem_o = '0;
  always @(negedge clk) begin
    if (en_d === 1'b1) begin n_en_d++; chain_d = {data_d, chain_d[63:1]}; end
    if (en_o === 1'b1) begin n_en_o++; mem_o = {data_o, mem_o[15:1]}; end
    if (en_w === 1'b1) begin n_en_w++; chain_w = {data_w, chain_w[63:2]}; end
  end

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [63:0] BITS2 = 64'h01234567_DEADBEEF;
  logic [15:0] exp_bits;
  int base;

  initial begin
    rst = 1'b1;
    start_d = 0; valid_d = 0; word_d = '0;
    start_o = 0; valid_o = 0; word_o = '0;
    start_w = 0; valid_w = 0; word_w = '0;
    exp_bits = 16'hA5C3;
    tick(); tick();
    chk("rst_ready", ready_d, 0); chk("rst_en", en_d, 0); chk("rst_data", data_d, 0);
    chk("rst_busy", busy_d, 0);   chk("rst_done", done_d, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy_d, 0);

    // Two words back to back, no stall
    start_d = 1; tick(); start_d = 0;
    chk("a_load_ready", ready_d, 1); chk("a_load_en", en_d, 0); chk("a_load_busy", busy_d, 1);
    word_d = 32'hDEADBEEF; valid_d = 1; tick();
    word_d = 32'h01234567;
    base = n_en_d;
    for (int i = 0; i < 64; i++) begin
      chk("a_en", en_d, 1);
      chk("a_ready", ready_d, (i == 31) ? 1 : 0);
      chk("a_done_low", done_d, 0);
      tick();
      if (i == 31) valid_d = 0;
    end
    chk("a_done", done_d, 1); chk("a_busy", busy_d, 0);
    chk("a_en_off", en_d, 0); chk("a_ready_off", ready_d, 0);
    chk("a_en_count", n_en_d - base, 64);
    chk("a_chain", chain_d, BITS2);

    // Restart from DONE, stall 5 cycles, start pulse ignored in SHIFT
    start_d = 1; tick(); start_d = 0;
    chk("b_done_drop", done_d, 0); chk("b_busy", busy_d, 1); chk("b_ready", ready_d, 1);
    chain_d = '0;
    word_d = 32'hDEADBEEF; valid_d = 1; tick(); valid_d = 0;
    base = n_en_d;
    for (int i = 0; i < 32; i++) begin
      chk("b_en1", en_d, 1);
      start_d = (i == 5) ? 1'b1 : 1'b0;
      tick();
    end
    start_d = 0;
    for (int k = 0; k < 5; k++) begin
      chk("b_stall_en", en_d, 0); chk("b_stall_ready", ready_d, 1);
      chk("b_stall_data", data_d, 0); chk("b_stall_busy", busy_d, 1);
      tick();
    end
    word_d = 32'h01234567; valid_d = 1; tick(); valid_d = 0;
    for (int i = 0; i < 32; i++) begin
      chk("b_en2", en_d, 1);
      tick();
    end
    chk("b_done", done_d, 1);
    chk("b_en_count", n_en_d - base, 64);
    chk("b_chain", chain_d, BITS2);

    // Asynchronous reset after 10 slices, then a clean reload
    start_d = 1; tick(); start_d = 0;
    word_d = 32'hDEADBEEF; valid_d = 1; tick(); valid_d = 0;
    repeat (10) tick();
    chk("c_mid_en", en_d, 1);
    #1 rst = 1'b1;
    #1;
    chk("c_rst_ready", ready_d, 0); chk("c_rst_en", en_d, 0); chk("c_rst_data", data_d, 0);
    chk("c_rst_busy", busy_d, 0);   chk("c_rst_done", done_d, 0);
    tick(); rst = 1'b0;
    tick();
    chk("c_idle_busy", busy_d, 0);
    base = n_en_d;
    chain_d = '0;
    start_d = 1; tick(); start_d = 0;
    word_d = 32'hDEADBEEF; valid_d = 1; tick();
    word_d = 32'h01234567;
    repeat (31) tick();
    chk("c_ready", ready_d, 1);
    tick(); valid_d = 0;
    repeat (32) tick();
    chk("c_done", done_d, 1);
    chk("c_en_count", n_en_d - base, 64);
    chk("c_chain", chain_d, BITS2);

    // One LUT: sixteen slices of 0xA5C3, upper half discarded
    start_o = 1; tick(); start_o = 0;
    chk("d_ready", ready_o, 1);
    word_o = 32'h0000A5C3; valid_o = 1; tick(); valid_o = 0;
    base = n_en_o;
    for (int i = 0; i < 16; i++) begin
      chk("d_en", en_o, 1);
      chk("d_bit", data_o, exp_bits[i]);
      chk("d_ready_low", ready_o, 0);
      tick();
    end
    chk("d_done", done_o, 1); chk("d_en_off", en_o, 0);
    chk("d_en_count", n_en_o - base, 16);
    chk("d_mem", mem_o, 16'hA5C3);
    chk("d_addr0", mem_o[0], 1); chk("d_addr15", mem_o[15], 1);

    // Two-bit slices: 32 enables for 4 LUTs
    start_w = 1; tick(); start_w = 0;
    word_w = 32'hDEADBEEF; valid_w = 1; tick();
    word_w = 32'h01234567;
    base = n_en_w;
    chk("e_first", data_w, 2'b11);
    repeat (15) tick();
    chk("e_ready", ready_w, 1);
    tick(); valid_w = 0;
    chk("e_second", data_w, 2'b11);
    repeat (16) tick();
    chk("e_done", done_w, 1);
    chk("e_en_count", n_en_w - base, 32);
    chk("e_chain", chain_w, BITS2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
